ram2_writer: RTL
================

Name: ram2_writer

Overview:
- Sequential write engine for the external Ram2 SRAM, which holds the instruction image that the instruction-fetch path reads combinationally.
- Accepts word write requests over a valid/ready handshake and generates timed active-low SRAM write cycles (EN/OE/WE, address, tri-stated data).
- Optionally reads each word back and flags mismatches.
- Sits between the program loader (boot/serial path) and the Ram2 pins; the pins are muxed with the fetch path outside this block, selected by busy.

Parameters:
- SETUP_CYCLES, 1, cycles that address/data are driven with WE high before the WE pulse (>=1).
- PULSE_CYCLES, 2, cycles that WE is held low (>=1).
- HOLD_CYCLES, 1, cycles that address/data are held after WE rises (>=1).
- READ_CYCLES, 2, cycles that OE is low during read-back; data is sampled on the last of these (>=1).
- VERIFY, 1, 1 = perform read-back compare after every write; 0 = write only.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- wr_valid  in  1  write request present
- wr_ready  out  1  block can accept a request (high only in IDLE)
- wr_addr  in  16  word address; zero-extended to 18 bits
- wr_data  in  16  word to write
- busy  out  1  high whenever state != IDLE; gives pin ownership to this block
- done  out  1  one-cycle pulse when a request has fully completed
- err  out  1  sticky read-back mismatch flag
- err_addr  out  16  address of the first mismatch since the last clear
- err_count  out  16  mismatch count, saturates at 0xFFFF
- err_clr  in  1  clears err, err_addr and err_count
- Ram2_EN  out  1  chip enable, active-low
- Ram2_OE  out  1  output enable, active-low
- Ram2_WE  out  1  write enable, active-low
- Ram2_address  out  18  SRAM address
- Ram2_data  inout  16  SRAM data bus

Behaviour:
- Reset values (asserted at the edge where rst=1):
  - Ram2_EN, Ram2_OE and Ram2_WE = 1.
  - Ram2_data = Z; Ram2_address = 0.
  - wr_ready, busy and done = 0.
  - err = 0, err_addr = 0, err_count = 0.
  - State = IDLE; wr_ready rises in the first cycle after rst falls.
- rst mid-operation aborts the write: at the next edge WE=1, bus=Z, state=IDLE, and no done pulse is issued. A partial SRAM write is acceptable.
- All Ram2 outputs are registered; no combinational path from the inputs to the pins.
- IDLE:
  - wr_ready=1, EN=1, OE=1, WE=1, bus=Z.
  - On wr_valid && wr_ready, latch addr and data, then go to SETUP.
- SETUP, SETUP_CYCLES cycles: EN=0, OE=1, WE=1, address={2'b0,addr}, bus driven with data.
- PULSE, PULSE_CYCLES cycles: as SETUP but WE=0.
- HOLD, HOLD_CYCLES cycles: WE=1; address and data unchanged.
  - Exit to READ if VERIFY=1, otherwise to IDLE with done=1.
- READ, READ_CYCLES cycles: bus=Z, EN=0, OE=0, WE=1, address unchanged.
  - Data is sampled and compared in the last cycle; then go to IDLE with done=1.
- Invariants:
  - Address and data are stable from the first SETUP cycle through the last HOLD cycle.
  - WE and OE are never low in the same cycle.
  - The bus is never driven while OE=0.
- Latency: if the request is accepted at the edge ending cycle T, done is high in cycle T+1+S+P+H (VERIFY=0) or T+1+S+P+H+R (VERIFY=1).
  - done coincides with the return to IDLE, so a new accept may occur in that same cycle (back-to-back).
- wr_valid while busy is ignored and nothing is latched; the requester holds its request until wr_ready.
- Mismatch handling:
  - err is set.
  - err_addr is captured only if err was 0 beforehand.
  - err_count increments, saturating at 0xFFFF.
- err_clr and a mismatch in the same cycle: the mismatch wins, giving err=1, err_addr=the new address and err_count=1.
- Phase counter: loads (N-1) on entry to each timed state and decrements; the state exits when the counter is 0.

Decomposition:
- Package ram2_pkg:
  - State enum: IDLE, SETUP, PULSE, HOLD, READ.
  - RAM_ON=1'b0 and RAM_OFF=1'b1.
  - Constants for the 18-bit address width, the 16-bit data width and the 16-bit all-Z bus value.
- One sub-module, ram2_phase_cnt: loadable down-counter with a zero flag, shared by all timed states.
- Tri-state bus driver and FSM live in ram2_writer.

Test Plan:
- Defaults, VERIFY=1: single write addr 0x0010 data 0x4901, SRAM model correct.
  - WE low for exactly 2 cycles; Ram2_address=0x00010 throughout.
  - done in cycle T+7; err stays 0.
- VERIFY=0: same request -> done in cycle T+5; OE never low; bus Z in IDLE.
- Two back-to-back requests (0x0000/0x1111, 0x0001/0x2222) with wr_valid held -> second accept in the cycle of the first done; the model contains both words.
- Model corrupts address 0x0003 (returns 0xDEAD), writes to 0x0002..0x0004 -> err=1, err_addr=0x0003, err_count=1; a later mismatch at 0x0005 gives count=2 while err_addr stays 0x0003.
- Assert rst during PULSE -> WE=1 and bus Z at the next edge; no done; wr_ready=1 one cycle after rst falls.
- Assert err_clr in the same cycle as a mismatch compare -> err=1, err_count=1, err_addr=the new address.

Source files
------------

// File: rtl/ram2_pkg.sv
// rtl/ram2_pkg.sv - shared types and constants for the Ram2 write engine
package ram2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    READ
  } state_e;

  localparam logic RAM_ON  = 1'b0;
  localparam logic RAM_OFF = 1'b1;

  localparam int ADDR_W = 18;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 8;

  localparam logic [DATA_W-1:0] BUS_Z = 16'hzzzz;

endpackage

// File: rtl/ram2_phase_cnt.sv
// rtl/ram2_phase_cnt.sv - loadable down-counter with zero flag for timed SRAM phases
module ram2_phase_cnt #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ram2_writer.sv
// rtl/ram2_writer.sv - timed Ram2 SRAM write engine with optional read-back verify
module ram2_writer
  import ram2_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES = 1,
  parameter int unsigned PULSE_CYCLES = 2,
  parameter int unsigned HOLD_CYCLES  = 1,
  parameter int unsigned READ_CYCLES  = 2,
  parameter int unsigned VERIFY       = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [15:0]       wr_addr,
  input  logic [15:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       err_addr,
  output logic [15:0]       err_count,
  input  logic              err_clr,
  output logic              Ram2_EN,
  output logic              Ram2_OE,
  output logic              Ram2_WE,
  output logic [ADDR_W-1:0] Ram2_address,
  inout  wire  [DATA_W-1:0] Ram2_data
);

  state_e              state_q, state_d;
  logic                ready_q, ready_d;
  logic                en_q, en_d;
  logic                oe_q, oe_d;
  logic                we_q, we_d;
  logic                drive_q, drive_d;
  logic                done_q, done_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                err_q, err_d;
  logic [15:0]         err_addr_q, err_addr_d;
  logic [15:0]         err_count_q, err_count_d;

  logic                accept;
  logic                phase_zero;
  logic                cnt_load;
  logic [CNT_W-1:0]    cnt_val;
  logic                mismatch;

  assign accept = wr_valid && ready_q && (state_q == IDLE);

  // Every timed state is entered from a different state, so a state change means a fresh phase.
  assign cnt_load = (state_d != state_q) && (state_d != IDLE);

  always_comb begin
    cnt_val = '0;
    case (state_d)
      SETUP:   cnt_val = CNT_W'(SETUP_CYCLES - 1);
      PULSE:   cnt_val = CNT_W'(PULSE_CYCLES - 1);
      HOLD:    cnt_val = CNT_W'(HOLD_CYCLES - 1);
      READ:    cnt_val = CNT_W'(READ_CYCLES - 1);
      default: cnt_val = '0;
    endcase
  end

  ram2_phase_cnt #(
    .W (CNT_W)
  ) u_phase_cnt (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .zero_o     (phase_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SETUP;
      SETUP:   if (phase_zero) state_d = PULSE;
      PULSE:   if (phase_zero) state_d = HOLD;
      HOLD:    if (phase_zero) state_d = (VERIFY != 0) ? READ : IDLE;
      READ:    if (phase_zero) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pin values are derived from the next state so the registered pins line up with it.
  always_comb begin
    en_d    = RAM_ON;
    oe_d    = RAM_OFF;
    we_d    = RAM_OFF;
    drive_d = 1'b0;
    case (state_d)
      IDLE:        en_d = RAM_OFF;
      SETUP, HOLD: drive_d = 1'b1;
      PULSE: begin
        we_d    = RAM_ON;
        drive_d = 1'b1;
      end
      READ:        oe_d = RAM_ON;
      default:     en_d = RAM_OFF;
    endcase
    ready_d = (state_d == IDLE);
    done_d  = (state_q != IDLE) && (state_d == IDLE);
    addr_d  = accept ? {2'b00, wr_addr} : addr_q;
    data_d  = accept ? wr_data : data_q;
  end

  assign mismatch = (state_q == READ) && phase_zero && (Ram2_data != data_q);

  // A mismatch in the same cycle as err_clr takes precedence and starts a fresh record.
  always_comb begin
    err_d       = err_q;
    err_addr_d  = err_addr_q;
    err_count_d = err_count_q;
    if (err_clr) begin
      err_d       = 1'b0;
      err_addr_d  = '0;
      err_count_d = '0;
    end
    if (mismatch) begin
      err_d = 1'b1;
      if (!err_q || err_clr) begin
        err_addr_d = addr_q[15:0];
      end
      if (err_clr) begin
        err_count_d = 16'd1;
      end else if (err_count_q != 16'hFFFF) begin
        err_count_d = err_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q     <= 1'b0;
      en_q        <= RAM_OFF;
      oe_q        <= RAM_OFF;
      we_q        <= RAM_OFF;
      drive_q     <= 1'b0;
      done_q      <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      err_q       <= 1'b0;
      err_addr_q  <= '0;
      err_count_q <= '0;
    end else begin
      ready_q     <= ready_d;
      en_q        <= en_d;
      oe_q        <= oe_d;
      we_q        <= we_d;
      drive_q     <= drive_d;
      done_q      <= done_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      err_q       <= err_d;
      err_addr_q  <= err_addr_d;
      err_count_q <= err_count_d;
    end
  end

  assign Ram2_data    = drive_q ? data_q : BUS_Z;
  assign Ram2_EN      = en_q;
  assign Ram2_OE      = oe_q;
  assign Ram2_WE      = we_q;
  assign Ram2_address = addr_q;
  assign wr_ready     = ready_q;
  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign err          = err_q;
  assign err_addr     = err_addr_q;
  assign err_count    = err_count_q;

endmodule
